clock_set_ctrl: RTL and testbench

//  Synchronous key-handling and mode sequencer for the clock's time and alarm adjustment path.

---
 rtl/clock_set_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Key debounce, mode sequencer and increment-pulse generator for the clock's
// time/alarm adjustment path. Valid/ready handshakes do not apply here: keys are level inputs.
module clock_set_ctrl #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd20000,
   parameter logic [23:0] REPEAT_DELAY    = 24'd500000,
   parameter logic [23:0] REPEAT_RATE     = 24'd100000,
   parameter logic [27:0] TIMEOUT         = 28'd10000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_mode,
   input  logic       key_turn,
   input  logic       key_change,
   output logic [1:0] mode,
   output logic       inc_time_min,
   output logic       inc_time_hour,
   output logic       inc_alarm_min,
   output logic       inc_alarm_hour,
   output logic       LD_min,
   output logic       LD_hour
);

   localparam int DB_W  = $clog2(int'(DEBOUNCE_CYCLES) + 1);
   localparam int RD_W  = $clog2(int'(REPEAT_DELAY) + 1);
   localparam int RR_W  = $clog2(int'(REPEAT_RATE) + 1);
   localparam int REP_W = (RD_W > RR_W) ? RD_W : RR_W;
   localparam int TMO_W = $clog2(int'(TIMEOUT) + 1);

   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(int'(DEBOUNCE_CYCLES) - 1);
   localparam logic [REP_W-1:0] RD_LAST  = REP_W'(int'(REPEAT_DELAY) - 1);
   localparam logic [REP_W-1:0] RR_LAST  = REP_W'(int'(REPEAT_RATE) - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(int'(TIMEOUT) - 1);

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      SET_ALARM = 2'd1,
      SET_TIME  = 2'd2
   } mode_e;

   typedef enum logic {
      HOUR = 1'b0,
      MIN  = 1'b1
   } field_e;

   // bit 0 = mode key, bit 1 = turn key, bit 2 = change key
   logic [2:0] key_raw;
   logic [2:0] press_evt;
   logic       chg_lvl;

   assign key_raw = {key_change, key_turn, key_mode};

   for (genvar k = 0; k < 3; k++) begin : g_key
      logic            sync1_q;
      logic            sync2_q;
      logic            lvl_q;
      logic            press_q;
      logic [DB_W-1:0] cnt_q;

      // The counter only runs while the synced level differs from the accepted
      // level, so any return to the accepted level reloads it.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
         end else begin
            sync1_q <= key_raw[k];
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == lvl_q) begin
               cnt_q <= '0;
            end else if (cnt_q == DB_LAST) begin
               cnt_q   <= '0;
               lvl_q   <= sync2_q;
               press_q <= sync2_q;
            end else begin
               cnt_q <= cnt_q + DB_W'(1);
            end
         end
      end

      assign press_evt[k] = press_q;

      if (k == 2) begin : g_lvl
         assign chg_lvl = lvl_q;
      end
   end

   mode_e            mode_q, mode_d;
   field_e           field_q, field_d;
   logic             rep_act_q, rep_act_d;
   logic             rep_ph_q, rep_ph_d;
   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic [REP_W-1:0] rep_lim;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [3:0]       inc_q, inc_d;
   logic [3:0]       tgt;
   logic             ld_min_q, ld_hour_q;

   // inc vector order: {time_min, time_hour, alarm_min, alarm_hour}
   assign tgt = {(mode_q == SET_TIME)  && (field_q == MIN),
                 (mode_q == SET_TIME)  && (field_q == HOUR),
                 (mode_q == SET_ALARM) && (field_q == MIN),
                 (mode_q == SET_ALARM) && (field_q == HOUR)};

   assign rep_lim = rep_ph_q ? RR_LAST : RD_LAST;

   always_comb begin
      mode_d    = mode_q;
      field_d   = field_q;
      rep_act_d = rep_act_q;
      rep_ph_d  = rep_ph_q;
      rep_cnt_d = rep_cnt_q;
      tmo_d     = tmo_q;
      inc_d     = '0;
      if (press_evt[0]) begin
         unique case (mode_q)
            RUN:       mode_d = SET_ALARM;
            SET_ALARM: mode_d = SET_TIME;
            default:   mode_d = RUN;
         endcase
         field_d   = HOUR;
         rep_act_d = 1'b0;
         rep_ph_d  = 1'b0;
         rep_cnt_d = '0;
         tmo_d     = '0;
      end else if (mode_q == RUN) begin
         rep_act_d = 1'b0;
         rep_ph_d  = 1'b0;
         rep_cnt_d = '0;
         tmo_d     = '0;
      end else if (press_evt[1]) begin
         if (field_q == HOUR) field_d = MIN;
         else                 field_d = HOUR;
         rep_ph_d  = 1'b0;
         rep_cnt_d = '0;
         tmo_d     = '0;
      end else if (press_evt[2]) begin
         inc_d     = tgt;
         rep_act_d = 1'b1;
         rep_ph_d  = 1'b0;
         rep_cnt_d = '0;
         tmo_d     = '0;
      end else if (tmo_q == TMO_LAST) begin
         mode_d    = RUN;
         field_d   = HOUR;
         rep_act_d = 1'b0;
         rep_ph_d  = 1'b0;
         rep_cnt_d = '0;
         tmo_d     = '0;
      end else begin
         // Repeat pulses deliberately leave the timeout counter running.
         tmo_d = tmo_q + TMO_W'(1);
         if (!chg_lvl) begin
            rep_act_d = 1'b0;
            rep_ph_d  = 1'b0;
            rep_cnt_d = '0;
         end else if (rep_act_q) begin
            if (rep_cnt_q == rep_lim) begin
               inc_d     = tgt;
               rep_ph_d  = 1'b1;
               rep_cnt_d = '0;
            end else begin
               rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q    <= RUN;
         field_q   <= HOUR;
         rep_act_q <= 1'b0;
         rep_ph_q  <= 1'b0;
         rep_cnt_q <= '0;
         tmo_q     <= '0;
         inc_q     <= '0;
         ld_min_q  <= 1'b0;
         ld_hour_q <= 1'b0;
      end else begin
         mode_q    <= mode_d;
         field_q   <= field_d;
         rep_act_q <= rep_act_d;
         rep_ph_q  <= rep_ph_d;
         rep_cnt_q <= rep_cnt_d;
         tmo_q     <= tmo_d;
         inc_q     <= inc_d;
         ld_min_q  <= (mode_d != RUN) && (field_d == MIN);
         ld_hour_q <= (mode_d != RUN) && (field_d == HOUR);
      end
   end

   assign mode = mode_q;
   assign {inc_time_min, inc_time_hour, inc_alarm_min, inc_alarm_hour} = inc_q;
   assign LD_min  = ld_min_q;
   assign LD_hour = ld_hour_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: table of single key presses plus hand-written
// sequences for latency, debounce, auto-repeat, timeout, priority and reset.
module tb_clock_set_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_mode = 1'b0;
   logic       key_turn = 1'b0;
   logic       key_change = 1'b0;
   logic [1:0] mode;
   logic       inc_time_min, inc_time_hour, inc_alarm_min, inc_alarm_hour;
   logic       LD_min, LD_hour;

   clock_set_ctrl #(
      .DEBOUNCE_CYCLES(16'd4),
      .REPEAT_DELAY   (24'd20),
      .REPEAT_RATE    (24'd5),
      .TIMEOUT        (28'd100)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .key_mode      (key_mode),
      .key_turn      (key_turn),
      .key_change    (key_change),
      .mode          (mode),
      .inc_time_min  (inc_time_min),
      .inc_time_hour (inc_time_hour),
      .inc_alarm_min (inc_alarm_min),
      .inc_alarm_hour(inc_alarm_hour),
      .LD_min        (LD_min),
      .LD_hour       (LD_hour)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   logic [3:0] inc_v;
   logic [7:0] outs;
   assign inc_v = {inc_time_min, inc_time_hour, inc_alarm_min, inc_alarm_hour};
   assign outs  = {mode, inc_v, LD_min, LD_hour};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic set_keys(input logic [2:0] keys);
      {key_change, key_turn, key_mode} = keys;
   endtask

   task automatic press_key(input logic [2:0] keys, input int hold);
      set_keys(keys);
      repeat (hold) @(negedge clk);
      set_keys(3'b000);
   endtask

   task automatic push_pulse(input int c, input logic [3:0] inc);
      exp_q.push_back({28'(c), inc});
   endtask

   // ---------------- scoreboard ----------------
   logic [31:0] exp_item;
   always @(negedge clk) begin
      if (inc_v != 4'b0000) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_inc: got cyc=%0d inc=%b expected no pulse", cyc, inc_v);
         end else begin
            exp_item = exp_q.pop_front();
            check("inc_pulse", {cyc[27:0], inc_v}, exp_item);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic [2:0] keys;
      logic [1:0] mode;
      logic       ld_min;
      logic       ld_hour;
      logic [3:0] inc;
   } vec_t;

   vec_t vec [14];

   initial begin
      int st, m, s, r;

      vec[0]  = '{3'b001, 2'd2, 1'b0, 1'b1, 4'b0000};
      vec[1]  = '{3'b001, 2'd0, 1'b0, 1'b0, 4'b0000};
      vec[2]  = '{3'b100, 2'd0, 1'b0, 1'b0, 4'b0000};
      vec[3]  = '{3'b010, 2'd0, 1'b0, 1'b0, 4'b0000};
      vec[4]  = '{3'b001, 2'd1, 1'b0, 1'b1, 4'b0000};
      vec[5]  = '{3'b010, 2'd1, 1'b1, 1'b0, 4'b0000};
      vec[6]  = '{3'b100, 2'd1, 1'b1, 1'b0, 4'b0010};
      vec[7]  = '{3'b010, 2'd1, 1'b0, 1'b1, 4'b0000};
      vec[8]  = '{3'b100, 2'd1, 1'b0, 1'b1, 4'b0001};
      vec[9]  = '{3'b010, 2'd1, 1'b1, 1'b0, 4'b0000};
      vec[10] = '{3'b001, 2'd2, 1'b0, 1'b1, 4'b0000};
      vec[11] = '{3'b100, 2'd2, 1'b0, 1'b1, 4'b0100};
      vec[12] = '{3'b010, 2'd2, 1'b1, 1'b0, 4'b0000};
      vec[13] = '{3'b100, 2'd2, 1'b1, 1'b0, 4'b1000};

      // reset state
      repeat (3) @(negedge clk);
      check("reset_outs", 32'(outs), 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // first mode press: change exactly 7 cycles after the raw edge
      st = cyc;
      press_key(3'b001, 6);
      tick_to(st + 6);
      check("lat_mode_before", 32'(mode), 32'd0);
      tick_to(st + 7);
      check("lat_mode_after", 32'(mode), 32'd1);
      check("lat_ld_hour", 32'(LD_hour), 32'd1);
      tick_to(st + 20);

      // table of single presses
      for (int i = 0; i < 14; i++) begin
         st = cyc;
         if (vec[i].inc != 4'b0000) push_pulse(st + 7, vec[i].inc);
         press_key(vec[i].keys, 6);
         tick_to(st + 20);
         check($sformatf("vec%0d_mode", i), 32'(mode), 32'(vec[i].mode));
         check($sformatf("vec%0d_ld", i), 32'({LD_min, LD_hour}), 32'({vec[i].ld_min, vec[i].ld_hour}));
      end

      // auto-repeat in SET_TIME/MIN; repeats must not hold off the timeout
      st = cyc;
      push_pulse(st + 7,  4'b1000);
      push_pulse(st + 27, 4'b1000);
      push_pulse(st + 32, 4'b1000);
      push_pulse(st + 37, 4'b1000);
      push_pulse(st + 42, 4'b1000);
      press_key(3'b100, 40);
      tick_to(st + 60);
      check("rep_all_seen", 32'(exp_q.size()), 32'd0);
      tick_to(st + 106);
      check("tmo_before", 32'(mode), 32'd2);
      tick_to(st + 107);
      check("tmo_after_outs", 32'(outs), 32'h0);

      // glitch and bounce on mode key: no step
      key_mode = 1'b1; repeat (3) @(negedge clk);
      key_mode = 1'b0; repeat (6) @(negedge clk);
      key_mode = 1'b1; @(negedge clk);
      key_mode = 1'b0; @(negedge clk);
      key_mode = 1'b1; @(negedge clk);
      key_mode = 1'b0; repeat (15) @(negedge clk);
      check("glitch_mode", 32'(mode), 32'd0);
      st = cyc;
      press_key(3'b001, 6);
      tick_to(st + 40);
      check("stable_one_step", 32'(mode), 32'd1);

      // turn press coinciding with timeout: press wins and restarts count
      m = cyc;
      press_key(3'b001, 6);
      tick_to(m + 7);
      check("enter_set_time", 32'(mode), 32'd2);
      tick_to(m + 100);
      press_key(3'b010, 6);
      tick_to(m + 108);
      check("coinc_mode", 32'(mode), 32'd2);
      check("coinc_ld_min", 32'(LD_min), 32'd1);
      tick_to(m + 206);
      check("restart_before", 32'(mode), 32'd2);
      tick_to(m + 207);
      check("restart_after_outs", 32'(outs), 32'h0);

      // mode and change pressed together: mode advances, no pulse
      st = cyc;
      press_key(3'b001, 6);
      tick_to(st + 20);
      s = cyc;
      press_key(3'b101, 6);
      tick_to(s + 7);
      check("simul_mode", 32'(mode), 32'd2);
      tick_to(s + 20);
      check("simul_outs", 32'(outs), 32'({2'd2, 4'b0000, 1'b0, 1'b1}));

      // reset while auto-repeat is active
      s = cyc;
      push_pulse(s + 7,  4'b0100);
      push_pulse(s + 27, 4'b0100);
      key_change = 1'b1;
      tick_to(s + 30);
      rst_n = 1'b0;
      #1;
      check("midreset_outs", 32'(outs), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      r = cyc;
      tick_to(r + 20);
      check("post_reset_outs", 32'(outs), 32'h0);
      key_change = 1'b0;
      repeat (10) @(negedge clk);
      st = cyc;
      press_key(3'b001, 6);
      tick_to(st + 7);
      check("recover_mode", 32'(mode), 32'd1);
      tick_to(st + 20);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
